// File: rtl/controllo_ricerca_stack_pkg.sv
// Shared definitions for the stack associative-search sequencer.
package controllo_ricerca_stack_pkg;

  // Sequencer states, 3-bit encoding.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_LOAD = 3'd2,
    S_WAIT = 3'd3,
    S_TEST = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Comparator result encoding: low means the operands are equal.
  localparam logic CMP_EQ = 1'b0;
  localparam logic CMP_NE = 1'b1;

  // Width of the settle counter; never narrower than one bit so that a
  // zero-wait configuration still elaborates.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/controllo_ricerca_stack_contatore_attesa.sv
// Loadable down-counter that times the comparator settle window.
// The terminal flag marks the last wait cycle (count == 1).
module contatore_attesa #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         term
);

  logic [W-1:0] cnt_d, cnt_q;

  // Load takes priority; decrement stops at zero so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term = (cnt_q == W'(1));

endmodule

// File: rtl/controllo_ricerca_stack.sv
// Associative stack search: scans entries sp-1 down to 0 through one shared
// equality comparator and reports the topmost matching index.
module controllo_ricerca_stack
  import controllo_ricerca_stack_pkg::*;
#(
  parameter int N        = 16,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  parameter int CMP_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [N-1:0]      key,
  input  logic [ADDR_W:0]   sp,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [N-1:0]      rd_data,
  output logic [N-1:0]      cmp_x1,
  output logic [N-1:0]      cmp_x2,
  input  logic              cmp_out,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] found_idx
);

  localparam int CNT_W = cnt_width(CMP_WAIT);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);
  localparam logic [CNT_W-1:0] WAIT_L = CNT_W'(CMP_WAIT);

  state_t            state_d, state_q;
  logic [ADDR_W-1:0] rd_addr_d, rd_addr_q;
  logic [N-1:0]      cmp_x1_d, cmp_x1_q;
  logic [N-1:0]      cmp_x2_d, cmp_x2_q;
  logic              found_d, found_q;
  logic [ADDR_W-1:0] found_idx_d, found_idx_q;

  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_term;
  logic [ADDR_W:0]   sp_sat;
  logic [ADDR_W:0]   sp_top;

  // Clamp the entry count to the physical depth and derive the top index.
  always_comb begin
    sp_sat = (sp > DEPTH_L) ? DEPTH_L : sp;
    sp_top = sp_sat - ONE_L;
  end

  // Settle timer: loaded in LOAD, counted down in WAIT.
  contatore_attesa #(
    .W (CNT_W)
  ) u_attesa (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (WAIT_L),
    .dec      (cnt_dec),
    .term     (cnt_term)
  );

  // Next-state and datapath updates. rd_addr doubles as the scan index.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    cmp_x1_d    = cmp_x1_q;
    cmp_x2_d    = cmp_x2_q;
    found_d     = found_q;
    found_idx_d = found_idx_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cmp_x1_d    = key;
          found_d     = 1'b0;
          found_idx_d = '0;
          if (sp_sat == '0) begin
            state_d = S_DONE;
          end else begin
            rd_addr_d = sp_top[ADDR_W-1:0];
            state_d   = S_READ;
          end
        end
      end

      // Storage read port is synchronous: give it one cycle on a stable address.
      S_READ: begin
        state_d = S_LOAD;
      end

      // Capture the stack word; operands then stay frozen until TEST.
      S_LOAD: begin
        cmp_x2_d = rd_data;
        cnt_load = 1'b1;
        state_d  = (CMP_WAIT == 0) ? S_TEST : S_WAIT;
      end

      S_WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_term) begin
          state_d = S_TEST;
        end
      end

      S_TEST: begin
        case (cmp_out)
          CMP_EQ: begin
            found_d     = 1'b1;
            found_idx_d = rd_addr_q;
            state_d     = S_DONE;
          end
          CMP_NE: begin
            if (rd_addr_q == '0) begin
              found_d = 1'b0;
              state_d = S_DONE;
            end else begin
              rd_addr_d = rd_addr_q - ADDR_W'(1);
              state_d   = S_READ;
            end
          end
        endcase
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any search in progress.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= '0;
      cmp_x1_q    <= '0;
      cmp_x2_q    <= '0;
      found_q     <= 1'b0;
      found_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      cmp_x1_q    <= cmp_x1_d;
      cmp_x2_q    <= cmp_x2_d;
      found_q     <= found_d;
      found_idx_q <= found_idx_d;
    end
  end

  assign rd_addr   = rd_addr_q;
  assign cmp_x1    = cmp_x1_q;
  assign cmp_x2    = cmp_x2_q;
  assign found     = found_q;
  assign found_idx = found_idx_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_controllo_ricerca_stack.sv
// Bench for controllo_ricerca_stack: two instances (settle wait 4 and 0)
// share stimulus and a stack image; results come from a scan model.
module tb_controllo_ricerca_stack;

  localparam int N     = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic [N-1:0]  key;
  logic [AW:0]   sp;
  logic [N-1:0]  mem [0:DEPTH-1];

  logic [AW-1:0] rd_addr4, fidx4, rd_addr0, fidx0;
  logic [N-1:0]  rd_data4, x1_4, x2_4, rd_data0, x1_0, x2_0;
  logic          cmp4, busy4, done4, found4;
  logic          cmp0, busy0, done0, found0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  always @(posedge clock) rd_data4 <= mem[rd_addr4];
  always @(posedge clock) rd_data0 <= mem[rd_addr0];
  assign cmp4 = (x1_4 === x2_4) ? 1'b0 : 1'b1;
  assign cmp0 = (x1_0 === x2_0) ? 1'b0 : 1'b1;

  controllo_ricerca_stack #(.N(N), .DEPTH(DEPTH), .ADDR_W(AW), .CMP_WAIT(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .start(start), .key(key), .sp(sp),
    .rd_addr(rd_addr4), .rd_data(rd_data4), .cmp_x1(x1_4), .cmp_x2(x2_4),
    .cmp_out(cmp4), .busy(busy4), .done(done4), .found(found4), .found_idx(fidx4));

  controllo_ricerca_stack #(.N(N), .DEPTH(DEPTH), .ADDR_W(AW), .CMP_WAIT(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .start(start), .key(key), .sp(sp),
    .rd_addr(rd_addr0), .rd_data(rd_data0), .cmp_x1(x1_0), .cmp_x2(x2_0),
    .cmp_out(cmp0), .busy(busy0), .done(done0), .found(found0), .found_idx(fidx0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Topmost match among the first min(sp,DEPTH) entries; counts entries examined.
  task automatic ref_search(input logic [N-1:0] k, input int spv,
                            output bit f, output int fi, output int nexam);
    int s;
    s = (spv > DEPTH) ? DEPTH : spv;
    f = 1'b0; fi = 0; nexam = s;
    for (int i = s - 1; i >= 0 && !f; i--) begin
      if (mem[i] == k) begin
        f = 1'b1; fi = i; nexam = s - i;
      end
    end
  endtask

  task automatic do_search(input logic [N-1:0] k_in, input logic [AW:0] sp_in,
                           input string tag, input bit poke);
    bit ef; int ei, ek, s, l4, l0, d4, d0, last;
    bit seq_ok;
    int addrq[$];
    ref_search(k_in, int'(sp_in), ef, ei, ek);
    s  = (int'(sp_in) > DEPTH) ? DEPTH : int'(sp_in);
    l4 = 1 + ek * 7;
    l0 = 1 + ek * 3;
    d4 = -1; d0 = -1;
    @(negedge clock);
    key = k_in; sp = sp_in; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int c = 1; c <= 200 && (d4 < 0 || d0 < 0); c++) begin
      if (poke && c == 3) begin start = 1'b1; key = ~k_in; sp = 4'd1; end
      if (poke && c == 4) start = 1'b0;
      if (d4 < 0 && !done4) begin
        if (c == 1 && s > 0) addrq.push_back(int'(rd_addr4));
        else if (addrq.size() > 0 && int'(rd_addr4) != addrq[$]) addrq.push_back(int'(rd_addr4));
      end
      if (done4 && d4 < 0) d4 = c;
      if (done0 && d0 < 0) d0 = c;
      if (d4 < 0 || d0 < 0) begin @(posedge clock); #1; end
    end
    chk({tag, "_lat_w4"}, d4, l4);
    chk({tag, "_lat_w0"}, d0, l0);
    chk({tag, "_found_w4"}, found4, ef);
    chk({tag, "_idx_w4"}, fidx4, ei);
    chk({tag, "_found_w0"}, found0, ef);
    chk({tag, "_idx_w0"}, fidx0, ei);
    chk({tag, "_key_w4"}, x1_4, k_in);
    last = ef ? ei : 0;
    seq_ok = (s == 0) ? (addrq.size() == 0) : (addrq.size() == s - last);
    if (seq_ok) foreach (addrq[j]) if (addrq[j] != s - 1 - j) seq_ok = 1'b0;
    chk({tag, "_addr_seq"}, seq_ok, 1);
    @(posedge clock); #1;
    chk({tag, "_idle_after"}, {busy4, done4, busy0, done0}, 4'b0000);
  endtask

  initial begin
    bit seen; int dn4 [2]; int dn0 [2]; int n4, n0;
    logic [N-1:0] kk; logic [AW:0] ss;
    reset_n = 1'b0; start = 1'b0; key = '0; sp = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    #2;
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_found", found4, 0);
    chk("rst_outs", {rd_addr4, x1_4, x2_4, fidx4}, '0);
    @(negedge clock); reset_n = 1'b1;

    // Empty stack
    do_search(16'hBEEF, 4'd0, "empty", 1'b0);

    // Top-of-stack hit
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h1111 * (i + 1);
    mem[4] = 16'h1234;
    do_search(16'h1234, 4'd5, "top_hit", 1'b0);

    // Bottom hit after a full scan
    for (int i = 1; i < DEPTH; i++) mem[i] = 16'hA000 + 16'(i);
    mem[0] = 16'h00FF;
    do_search(16'h00FF, 4'd8, "bottom_hit", 1'b0);

    // Miss, then duplicates
    do_search(16'h5555, 4'd8, "miss", 1'b0);
    mem[2] = 16'hCAFE; mem[6] = 16'hCAFE;
    do_search(16'hCAFE, 4'd8, "dup", 1'b0);

    // Oversized sp clamps to DEPTH
    do_search(mem[7], 4'd12, "sp_sat", 1'b0);

    // Start pulsed while busy with a different key is ignored
    do_search(16'h5555, 4'd8, "poke", 1'b1);

    // Start held high: back-to-back searches with one IDLE cycle between
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h3000 + 16'(i);
    mem[1] = 16'h4242;
    n4 = 0; n0 = 0; dn4 = '{-1, -1}; dn0 = '{-1, -1};
    @(negedge clock); key = 16'h4242; sp = 4'd3; start = 1'b1;
    @(posedge clock); #1;
    for (int c = 1; c <= 31; c++) begin
      if (done4 && n4 < 2) begin dn4[n4] = c; n4++; end
      if (done0 && n0 < 2) begin dn0[n0] = c; n0++; end
      if (c == 16) chk("held_idle_gap", busy4, 0);
      if (c == 17) chk("held_restart", busy4, 1);
      if (c < 31) begin @(posedge clock); #1; end
    end
    start = 1'b0;
    chk("held_done1_w4", dn4[0], 15);
    chk("held_done2_w4", dn4[1], 31);
    chk("held_done1_w0", dn0[0], 7);
    chk("held_done2_w0", dn0[1], 15);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(posedge clock); #1;
      if (!busy4 && !busy0) seen = 1'b1;
    end
    chk("held_drain", seen, 1);

    // Randomized searches over a small value alphabet (hits and duplicates)
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom_range(0, 3));
      kk = 16'($urandom_range(0, 4));
      ss = 4'($urandom_range(0, 15));
      do_search(kk, ss, $sformatf("rand%0d", r), 1'b0);
    end

    // Reset in the middle of WAIT
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h6000 + 16'(i);
    @(negedge clock); key = 16'h7777; sp = 4'd8; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    chk("pre_rst_busy", busy4, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", {busy4, busy0}, 2'b00);
    chk("mid_rst_done", {done4, done0}, 2'b00);
    chk("mid_rst_found", {found4, found0}, 2'b00);
    chk("mid_rst_outs", {rd_addr4, x1_4, x2_4, fidx4}, '0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clock); #1;
      if (done4 || done0 || busy4 || busy0) seen = 1'b1;
    end
    chk("post_rst_quiet", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
